// File: rtl/bsg_rocket_pkg.sv
// Shared configuration and types for the multi-channel host bridge.
// No logic; constants, the host word layout and a clog2 helper.
// Not applicable (package only).
package bsg_rocket_pkg;

   // Width helper: never returns 0, so a one-channel bridge still has a 1-bit id field.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int bsg_host_mc_cfg_width_p    = 40;
   localparam int bsg_host_mc_cfg_channels_p = 2;
   localparam int bsg_host_mc_cfg_els_p      = 4;
   localparam int bsg_host_mc_cfg_id_width_lp = safe_clog2(bsg_host_mc_cfg_channels_p);

   // Host word for the default configuration: channel tag above the payload.
   typedef struct packed {
      logic [bsg_host_mc_cfg_id_width_lp-1:0] id;
      logic [bsg_host_mc_cfg_width_p-1:0]     payload;
   } bsg_host_mc_word_t;

endpackage

// File: rtl/bsg_host_mc_fifo.sv
// Per-channel circular FIFO, width_p x els_p, all els_p entries usable.
// Latency: enqueue at t is visible at the head at t+1.
// Backpressure: ready_o is a registered ~full and does not depend on yumi_i.
module bsg_host_mc_fifo
   import bsg_rocket_pkg::*;
#(
   parameter int width_p = 40,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = safe_clog2(els_p);
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  mem_q [els_p];
   logic [width_p-1:0]  mem_d [els_p];
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                full_q, full_d;
   logic                enq, deq;

   assign enq     = v_i & ~full_q;
   assign deq     = yumi_i & (count_q != '0);
   assign ready_o = ~full_q;
   assign v_o     = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

   // Next-state: write at tail, advance pointers with wrap, track occupancy and full flag.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d = (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq) begin
         rd_ptr_d = (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d = (count_d == cnt_w_lp'(els_p));
   end

   // State registers; reset empties the FIFO and clears storage.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

endmodule

// File: rtl/bsg_host_mc.sv
// Multi-channel host bridge: tagged host stream steered into per-channel FIFOs; channels RR-merged to host.
// Latency: host->channel 1 cycle; channel->host 1 cycle through a registered output slot.
// Backpressure: full channel stalls host (head-of-line); host_ready_i=0 holds the slot and stops yumi_o.
module bsg_host_mc
   import bsg_rocket_pkg::*;
#(
   parameter  int width_p       = bsg_host_mc_cfg_width_p,
   parameter  int channels_p    = bsg_host_mc_cfg_channels_p,
   parameter  int els_p         = bsg_host_mc_cfg_els_p,
   localparam int id_width_lp   = safe_clog2(channels_p),
   localparam int host_width_lp = id_width_lp + width_p
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          host_valid_i,
   input  logic [host_width_lp-1:0]      host_data_i,
   output logic                          host_ready_o,
   output logic                          host_valid_o,
   output logic [host_width_lp-1:0]      host_data_o,
   input  logic                          host_ready_i,
   input  logic [channels_p-1:0]         valid_i,
   input  logic [channels_p*width_p-1:0] data_i,
   output logic [channels_p-1:0]         yumi_o,
   output logic [channels_p-1:0]         valid_o,
   output logic [channels_p*width_p-1:0] data_o,
   input  logic [channels_p-1:0]         yumi_i,
   output logic                          drop_o
);

   // en_q keeps every handshake output low while reset is (or was just) asserted.
   logic                          en_q, en_d;
   logic                          drop_q, drop_d;
   logic                          slot_vld_q, slot_vld_d;
   logic [host_width_lp-1:0]      slot_dat_q, slot_dat_d;
   logic [id_width_lp-1:0]        rr_q, rr_d;

   logic [id_width_lp-1:0]        host_id;
   logic                          id_ok;
   logic                          host_hs;
   logic [channels_p-1:0]         fifo_ready;
   logic [channels_p-1:0]         fifo_enq;
   logic [(1<<id_width_lp)-1:0]   fifo_ready_pad;

   logic                          slot_free;
   logic                          grant_found;
   logic [id_width_lp-1:0]        grant_id;
   int                            scan_idx;

   assign host_id = host_data_i[host_width_lp-1 -: id_width_lp];
   assign id_ok   = (int'(host_id) < channels_p);

   // Pad per-channel ready to the full id range so out-of-range ids index safely.
   always_comb begin
      fifo_ready_pad = '0;
      fifo_ready_pad[channels_p-1:0] = fifo_ready;
   end

   assign host_ready_o = en_q & (id_ok ? fifo_ready_pad[host_id] : 1'b1);
   assign host_hs      = host_valid_i & host_ready_o;

   for (genvar c = 0; c < channels_p; c++) begin : g_ch
      assign fifo_enq[c] = host_hs & id_ok & (host_id == id_width_lp'(c));
      bsg_host_mc_fifo #(
         .width_p (width_p),
         .els_p   (els_p)
      ) u_fifo (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .v_i       (fifo_enq[c]),
         .data_i    (host_data_i[width_p-1:0]),
         .ready_o   (fifo_ready[c]),
         .v_o       (valid_o[c]),
         .data_o    (data_o[c*width_p +: width_p]),
         .yumi_i    (yumi_i[c])
      );
   end

   assign slot_free    = ~slot_vld_q | host_ready_i;
   assign host_valid_o = slot_vld_q;
   assign host_data_o  = slot_dat_q;

   // Round-robin scan from the pointer, then load/drain the output slot and advance the pointer.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = 0;
      for (int i = 0; i < channels_p; i++) begin
         scan_idx = (int'(rr_q) + i) % channels_p;
         if (!grant_found && valid_i[scan_idx]) begin
            grant_found = 1'b1;
            grant_id    = id_width_lp'(scan_idx);
         end
      end
      yumi_o     = '0;
      slot_vld_d = slot_vld_q;
      slot_dat_d = slot_dat_q;
      rr_d       = rr_q;
      if (en_q && slot_free && grant_found) begin
         yumi_o[grant_id] = 1'b1;
         slot_vld_d = 1'b1;
         slot_dat_d = {grant_id, data_i[grant_id*width_p +: width_p]};
         rr_d       = (int'(grant_id) + 1 == channels_p) ? '0 : grant_id + 1'b1;
      end else if (host_ready_i) begin
         slot_vld_d = 1'b0;
      end
      en_d   = 1'b1;
      drop_d = host_hs & ~id_ok;
   end

   // State registers for enable, drop pulse, output slot and RR pointer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         en_q       <= 1'b0;
         drop_q     <= 1'b0;
         slot_vld_q <= 1'b0;
         slot_dat_q <= '0;
         rr_q       <= '0;
      end else begin
         en_q       <= en_d;
         drop_q     <= drop_d;
         slot_vld_q <= slot_vld_d;
         slot_dat_q <= slot_dat_d;
         rr_q       <= rr_d;
      end
   end

   assign drop_o = drop_q;

endmodule
